// File: rtl/rgb_to_cfa_mosaic_if.sv
// Valid/ready bundle between an RGB raster source (master) and the CFA re-mosaic block (slave).
interface rgb_to_cfa_mosaic_if #(
   parameter int DataBitWidth = 12
);
   logic [DataBitWidth+1:0] in_R;
   logic [DataBitWidth+1:0] in_G;
   logic [DataBitWidth+1:0] in_B;
   logic                    in_sof;
   logic                    in_eol;
   logic                    in_valid;
   logic                    in_ready;
   logic [DataBitWidth-1:0] out_cfa;
   logic                    out_sof;
   logic                    out_eol;
   logic                    out_valid;
   logic                    out_ready;
   logic                    err_line;

   modport slave (
      input  in_R, in_G, in_B, in_sof, in_eol, in_valid, out_ready,
      output in_ready, out_cfa, out_sof, out_eol, out_valid, err_line
   );

   modport master (
      output in_R, in_G, in_B, in_sof, in_eol, in_valid, out_ready,
      input  in_ready, out_cfa, out_sof, out_eol, out_valid, err_line
   );
endinterface

// File: rtl/rgb_to_cfa_mosaic.sv
// Re-mosaics an RGB raster into a Bayer CFA stream behind a 2-entry skid buffer.
// Define CFA_CLIP_EN to treat inputs as two's complement and saturate the selected sample.
module rgb_to_cfa_mosaic #(
   parameter int DataBitWidth = 12,
   parameter int ImgWidth     = 1920,
   parameter int ImgHeight    = 1080,
   parameter int Pattern      = 0
) (
   input  logic               clk,
   input  logic               rst,
   rgb_to_cfa_mosaic_if.slave bus_io
);
   localparam int SW = DataBitWidth + 2;
   localparam int CW = (ImgWidth > 1) ? $clog2(ImgWidth) : 1;
   localparam int RW = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(ImgWidth - 1);
   localparam logic [CW-1:0] COL_ONE  = CW'(1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ImgHeight - 1);
   localparam logic [RW-1:0] ROW_ONE  = RW'(1);
   localparam logic [1:0]    PHASE    = 2'(Pattern);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_e;

   typedef struct packed {
      logic [DataBitWidth-1:0] cfa;
      logic                    sof;
      logic                    eol;
   } beat_t;

   state_e                  state_q, state_d;
   logic [CW-1:0]           col_q, col_d, col_cur_s;
   logic [RW-1:0]           row_q, row_d, row_cur_s;
   logic                    accept_s, proc_s;
   logic                    last_col_s, line_end_s, frame_end_s;
   logic [1:0]              site_s;
   logic [SW-1:0]           sel_s;
   logic [DataBitWidth-1:0] cfa_s;
   beat_t                   beat_s, main_q, main_d, skid_q, skid_d;
   logic                    main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic                    err_q, err_d, main_free_s;

`ifdef CFA_CLIP_EN
   function automatic logic [DataBitWidth-1:0] fit_sample(input logic [SW-1:0] raw);
      logic [DataBitWidth-1:0] res;
      if (raw[SW-1]) begin
         res = {DataBitWidth{1'b0}};
      end else if (raw[DataBitWidth]) begin
         res = {DataBitWidth{1'b1}};
      end else begin
         res = raw[DataBitWidth-1:0];
      end
      return res;
   endfunction

   assign cfa_s = fit_sample(sel_s);
`else
   logic [1:0] sel_hi_unused_s;

   assign cfa_s           = sel_s[DataBitWidth-1:0];
   assign sel_hi_unused_s = sel_s[SW-1:SW-2];
`endif

   // The skid entry being occupied is the only thing that throttles the source.
   assign accept_s = bus_io.in_valid & ~skid_v_q;
   assign beat_s   = '{cfa: cfa_s, sof: bus_io.in_sof, eol: bus_io.in_eol};

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a one-pixel frame opens and closes on the same beat
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (proc_s && !frame_end_s) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (proc_s && frame_end_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM output: in IDLE only a sof beat is processed, the rest are dropped
   always_comb begin
      proc_s = 1'b0;
      case (state_q)
         ST_IDLE:   proc_s = accept_s & bus_io.in_sof;
         ST_ACTIVE: proc_s = accept_s;
         default:   proc_s = 1'b0;
      endcase
   end

   // Raster position of the current beat (sof resyncs first) and channel pick
   always_comb begin
      row_cur_s = row_q;
      col_cur_s = col_q;
      if (bus_io.in_sof) begin
         row_cur_s = {RW{1'b0}};
         col_cur_s = {CW{1'b0}};
      end else begin
         row_cur_s = row_q;
         col_cur_s = col_q;
      end
      last_col_s  = (col_cur_s == COL_LAST);
      line_end_s  = last_col_s | bus_io.in_eol;
      frame_end_s = last_col_s & (row_cur_s == ROW_LAST);

      col_d = col_q;
      row_d = row_q;
      if (proc_s && line_end_s) begin
         col_d = {CW{1'b0}};
         if (row_cur_s == ROW_LAST) begin
            row_d = {RW{1'b0}};
         end else begin
            row_d = row_cur_s + ROW_ONE;
         end
      end else if (proc_s) begin
         col_d = col_cur_s + COL_ONE;
         row_d = row_cur_s;
      end else begin
         col_d = col_q;
         row_d = row_q;
      end

      site_s = {row_cur_s[0], col_cur_s[0]} ^ PHASE;
      case (site_s)
         2'b00:   sel_s = bus_io.in_R;
         2'b11:   sel_s = bus_io.in_B;
         default: sel_s = bus_io.in_G;
      endcase
   end

   // Output register plus skid entry; the skid only fills while the head is stalled
   always_comb begin
      main_free_s = ~main_v_q | bus_io.out_ready;
      main_d      = main_q;
      main_v_d    = main_v_q;
      skid_d      = skid_q;
      skid_v_d    = skid_v_q;
      if (main_free_s && skid_v_q) begin
         main_d   = skid_q;
         main_v_d = 1'b1;
         skid_v_d = proc_s;
         if (proc_s) begin
            skid_d = beat_s;
         end else begin
            skid_d = skid_q;
         end
      end else if (main_free_s) begin
         main_v_d = proc_s;
         if (proc_s) begin
            main_d = beat_s;
         end else begin
            main_d = main_q;
         end
      end else if (proc_s) begin
         skid_d   = beat_s;
         skid_v_d = 1'b1;
      end else begin
         skid_d   = skid_q;
         skid_v_d = skid_v_q;
      end
      err_d = proc_s & (bus_io.in_eol ^ last_col_s);
   end

   // Counters, buffer and error pulse registers; reset flushes anything in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q    <= {CW{1'b0}};
         row_q    <= {RW{1'b0}};
         main_q   <= '{cfa: {DataBitWidth{1'b0}}, sof: 1'b0, eol: 1'b0};
         skid_q   <= '{cfa: {DataBitWidth{1'b0}}, sof: 1'b0, eol: 1'b0};
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         err_q    <= err_d;
      end
   end

   assign bus_io.in_ready  = ~skid_v_q;
   assign bus_io.out_cfa   = main_q.cfa;
   assign bus_io.out_sof   = main_q.sof;
   assign bus_io.out_eol   = main_q.eol;
   assign bus_io.out_valid = main_v_q;
   assign bus_io.err_line  = err_q;
endmodule

// File: tb/tb_rgb_to_cfa_mosaic.sv
// Bench for rgb_to_cfa_mosaic: two instances (RGGB and BGGR) share one stimulus stream,
// checked against a vector table and a raster-position scoreboard.
module tb_rgb_to_cfa_mosaic;
   localparam int DW = 12;
   localparam int SW = DW + 2;
   localparam int W  = 4;
   localparam int H  = 2;

`ifdef CFA_CLIP_EN
   localparam int EXP_M5 = 0, EXP_5000 = 4095, EXP_4096 = 4095, EXP_M1 = 0;
`else
   localparam int EXP_M5 = 4091, EXP_5000 = 904, EXP_4096 = 0, EXP_M1 = 4095;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [SW-1:0] r_v, g_v, b_v;
   logic          sof_v, eol_v, valid_v, ordy_v;

   rgb_to_cfa_mosaic_if #(.DataBitWidth(DW)) if0 ();
   rgb_to_cfa_mosaic_if #(.DataBitWidth(DW)) if3 ();

   assign if0.in_R = r_v;     assign if3.in_R = r_v;
   assign if0.in_G = g_v;     assign if3.in_G = g_v;
   assign if0.in_B = b_v;     assign if3.in_B = b_v;
   assign if0.in_sof = sof_v; assign if3.in_sof = sof_v;
   assign if0.in_eol = eol_v; assign if3.in_eol = eol_v;
   assign if0.in_valid = valid_v;  assign if3.in_valid = valid_v;
   assign if0.out_ready = ordy_v;  assign if3.out_ready = ordy_v;

   rgb_to_cfa_mosaic #(.DataBitWidth(DW), .ImgWidth(W), .ImgHeight(H), .Pattern(0)) dut0 (
      .clk(clk), .rst(rst), .bus_io(if0.slave));
   rgb_to_cfa_mosaic #(.DataBitWidth(DW), .ImgWidth(W), .ImgHeight(H), .Pattern(3)) dut3 (
      .clk(clk), .rst(rst), .bus_io(if3.slave));

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [SW-1:0] r, g, b;
      int row, col;
      bit sof, eol;
   } pix_t;

   pix_t exp_q[$];
   bit   m_active;
   int   m_row, m_col;
   bit   exp_err;
   bit   last_acc;

   typedef struct {
      bit sof; bit eol; int r; int g; int b;
      bit exp_v; int cfa0; int cfa3; bit err;
   } vec_t;
   vec_t tbl[$];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int ref_fit(input logic [SW-1:0] raw);
      int v;
`ifdef CFA_CLIP_EN
      v = raw[SW-1] ? int'(raw) - (1 << SW) : int'(raw);
      if (v < 0) v = 0;
      else if (v > (1 << DW) - 1) v = (1 << DW) - 1;
`else
      v = int'(raw) % (1 << DW);
`endif
      return v;
   endfunction

   // Colour at a site read straight from the named 2x2 Bayer tile.
   function automatic int ref_cfa(input int pat, input pix_t p);
      string layout;
      byte   ch;
      case (pat)
         0:       layout = "RGGB";
         1:       layout = "GRBG";
         2:       layout = "GBRG";
         default: layout = "BGGR";
      endcase
      ch = layout.getc(2 * (p.row % 2) + (p.col % 2));
      if (ch == "R") return ref_fit(p.r);
      else if (ch == "B") return ref_fit(p.b);
      else return ref_fit(p.g);
   endfunction

   function automatic void model_beat(input bit acc);
      pix_t p;
      bit   frame_done;
      exp_err = 1'b0;
      if (acc && (m_active || sof_v)) begin
         if (sof_v) begin
            m_row = 0; m_col = 0; m_active = 1'b1;
         end
         p.r = r_v; p.g = g_v; p.b = b_v;
         p.row = m_row; p.col = m_col; p.sof = sof_v; p.eol = eol_v;
         exp_q.push_back(p);
         exp_err = (eol_v != (m_col == W - 1));
         frame_done = (m_row == H - 1) && (m_col == W - 1);
         if (m_col == W - 1 || eol_v) begin
            m_col = 0;
            m_row = (m_row + 1) % H;
         end else begin
            m_col++;
         end
         if (frame_done) m_active = 1'b0;
      end
   endfunction

   // One clock: check the settled outputs, predict the coming edge, advance.
   task automatic step();
      pix_t hd;
      bit   fire;
      check("in_ready_p0", if0.in_ready, exp_q.size() < 2);
      check("in_ready_p3", if3.in_ready, exp_q.size() < 2);
      check("out_valid_p0", if0.out_valid, exp_q.size() != 0);
      check("out_valid_p3", if3.out_valid, exp_q.size() != 0);
      check("err_line_p0", if0.err_line, exp_err);
      check("err_line_p3", if3.err_line, exp_err);
      if (exp_q.size() != 0) begin
         hd = exp_q[0];
         check("sb_cfa_p0", if0.out_cfa, ref_cfa(0, hd));
         check("sb_cfa_p3", if3.out_cfa, ref_cfa(3, hd));
         check("sb_sof_p0", if0.out_sof, hd.sof);
         check("sb_eol_p3", if3.out_eol, hd.eol);
      end
      fire     = (exp_q.size() != 0) && ordy_v;
      last_acc = valid_v && (exp_q.size() < 2);
      if (fire) void'(exp_q.pop_front());
      model_beat(last_acc);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid_v = 1'b0; sof_v = 1'b0; eol_v = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_active = 1'b0; m_row = 0; m_col = 0; exp_err = 1'b0; last_acc = 1'b0;
   endtask

   task automatic check_reset();
      check("rst_cfa_p0", if0.out_cfa, 0);
      check("rst_sof_p0", if0.out_sof, 0);
      check("rst_eol_p0", if0.out_eol, 0);
      check("rst_valid_p0", if0.out_valid, 0);
      check("rst_err_p0", if0.err_line, 0);
      check("rst_ready_p0", if0.in_ready, 1);
      check("rst_valid_p3", if3.out_valid, 0);
      check("rst_ready_p3", if3.in_ready, 1);
   endtask

   task automatic new_beat(input bit sof);
      int nc;
      nc    = sof ? 0 : m_col;
      sof_v = sof;
      eol_v = (nc == W - 1);
      r_v = SW'($urandom); g_v = SW'($urandom); b_v = SW'($urandom);
   endtask

   function automatic void add(input bit sof, input bit eol, input int r, input int g,
                               input int b, input bit v, input int c0, input int c3,
                               input bit err);
      vec_t t;
      t.sof = sof; t.eol = eol; t.r = r; t.g = g; t.b = b;
      t.exp_v = v; t.cfa0 = c0; t.cfa3 = c3; t.err = err;
      tbl.push_back(t);
   endfunction

   initial begin
      int   nc;
      logic [DW-1:0] held0, held3;

      // sof, eol, R, G, B, out_valid, cfa RGGB, cfa BGGR, err_line
      add(0, 0, 100, 200, 300, 0, 0, 0, 0);            // no sof after reset: dropped
      add(0, 1, 100, 200, 300, 0, 0, 0, 0);
      add(1, 0, 100, 200, 300, 1, 100, 300, 0);        // 4x2 frame
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 100, 300, 0);
      add(0, 1, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 300, 100, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 1, 100, 200, 300, 1, 300, 100, 0);
      add(0, 0, 100, 200, 300, 0, 0, 0, 0);            // back in IDLE
      add(1, 0, 100, 200, 300, 1, 100, 300, 0);        // early eol at col 2
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 1, 100, 200, 300, 1, 100, 300, 1);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 300, 100, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 300, 100, 1);        // missing eol at last col
      add(0, 0, 100, 200, 300, 0, 0, 0, 0);
      add(1, 1, 100, 200, 300, 1, 100, 300, 1);        // sof and eol together
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 300, 100, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 1, 100, 200, 300, 1, 300, 100, 0);
      add(1, 0, -5, 200, 300, 1, EXP_M5, 300, 0);      // out-of-range samples
      add(0, 0, -5, 200, 300, 1, 200, 200, 0);
      add(0, 0, 5000, 200, 300, 1, EXP_5000, 300, 0);
      add(0, 1, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 0, 4096, 200, -1, 1, EXP_M1, EXP_4096, 0);
      add(0, 0, 100, 200, 300, 1, 200, 200, 0);
      add(0, 1, 100, 200, 300, 1, 300, 100, 0);

      rst = 1'b1; valid_v = 1'b0; ordy_v = 1'b1; sof_v = 1'b0; eol_v = 1'b0;
      r_v = '0; g_v = '0; b_v = '0;
      do_reset();
      check_reset();

      foreach (tbl[i]) begin
         sof_v = tbl[i].sof; eol_v = tbl[i].eol; valid_v = 1'b1;
         r_v = SW'(tbl[i].r); g_v = SW'(tbl[i].g); b_v = SW'(tbl[i].b);
         step();
         check($sformatf("vec%0d_valid", i), if0.out_valid, tbl[i].exp_v);
         check($sformatf("vec%0d_err", i), if0.err_line, tbl[i].err);
         if (tbl[i].exp_v) begin
            check($sformatf("vec%0d_cfa_p0", i), if0.out_cfa, tbl[i].cfa0);
            check($sformatf("vec%0d_cfa_p3", i), if3.out_cfa, tbl[i].cfa3);
            check($sformatf("vec%0d_sof", i), if0.out_sof, tbl[i].sof);
            check($sformatf("vec%0d_eol", i), if3.out_eol, tbl[i].eol);
         end
      end
      valid_v = 1'b0;
      step();

      // Downstream stall mid-line with the source pushing every cycle
      valid_v = 1'b1; ordy_v = 1'b1;
      new_beat(1'b1);
      step();
      new_beat(1'b0);
      step();
      new_beat(1'b0);
      ordy_v = 1'b0;
      held0 = if0.out_cfa; held3 = if3.out_cfa;
      for (int k = 0; k < 5; k++) begin
         step();
         if (last_acc) new_beat(1'b0);
         check($sformatf("stall%0d_in_ready", k), if0.in_ready, 0);
         check($sformatf("stall%0d_hold_p0", k), if0.out_cfa, held0);
         check($sformatf("stall%0d_hold_p3", k), if3.out_cfa, held3);
         check($sformatf("stall%0d_valid", k), if0.out_valid, 1);
      end
      ordy_v = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         if (last_acc) new_beat(1'b0);
      end

      // Randomized traffic, back-pressure, stray sof/eol and a mid-frame reset
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            do_reset();
            check_reset();
         end
         if (!valid_v || last_acc) begin
            valid_v = ($urandom_range(0, 3) != 0);
            sof_v   = ($urandom_range(0, 40) == 0) || (!m_active && $urandom_range(0, 2) == 0);
            nc      = sof_v ? 0 : m_col;
            if ($urandom_range(0, 15) == 0) eol_v = 1'($urandom_range(0, 1));
            else eol_v = (nc == W - 1);
            r_v = SW'($urandom); g_v = SW'($urandom); b_v = SW'($urandom);
         end
         ordy_v = ($urandom_range(0, 3) != 0);
         step();
      end

      valid_v = 1'b0; ordy_v = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (exp_q.size() != 0) step();
      end
      check("drain_idle_p0", if0.out_valid, 0);
      check("drain_idle_p3", if3.out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
